wb_trace_buffer: RTL and testbench
==================================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter CNT_W, default 16, width of the drop counter.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port debug_wb_pc  input  32  PC of the retiring instruction, from the CPU writeback stage.
REQ-006 Port debug_wb_rf_wen  input  4  register-file byte write enables from writeback.
REQ-007 Port debug_wb_rf_wnum  input  5  destination register number.
REQ-008 Port debug_wb_rf_wdata  input  32  value written to the register file.
REQ-009 Port clear  input  1  clears the overflow flag and the drop counter.
REQ-010 Port trace_valid  output  1  head entry available.
REQ-011 Port trace_ready  input  1  consumer accepts the head entry.
REQ-012 Port trace_pc  output  32  head entry PC.
REQ-013 Port trace_wnum  output  5  head entry register number.
REQ-014 Port trace_wdata  output  32  head entry write data.
REQ-015 Port fifo_count  output  log2(DEPTH)+1  current occupancy.
REQ-016 Port overflow  output  1  sticky flag: at least one event was dropped.
REQ-017 Port drop_cnt  output  CNT_W  number of dropped events, saturating.

Function
REQ-018 Capture event: debug_wb_rf_wen != 4'b0000 and debug_wb_rf_wnum != 0. Write-enables to $0 SHALL NOT be captured.
REQ-019 Push: a capture event with (fifo_count < DEPTH) or pop in the same cycle SHALL write {pc, wnum, wdata} at the tail on that edge.
REQ-020 Pop: trace_valid && trace_ready SHALL retire the head entry on that edge.
REQ-021 Show-ahead: trace_valid SHALL equal (fifo_count != 0). trace_pc, trace_wnum and trace_wdata SHALL always present the head entry, combinationally from storage.
REQ-022 Latency: an entry pushed at edge N SHALL be visible at the outputs after edge N. There SHALL be no same-cycle bypass, so an empty FIFO with a capture event keeps trace_valid=0 in that cycle.
REQ-023 Ordering SHALL be strict FIFO. Head and tail pointers SHALL wrap modulo DEPTH.
REQ-024 Simultaneous push and pop SHALL leave fifo_count unchanged. This also applies when the FIFO is full: the pop frees the slot and the push is accepted with no drop.
REQ-025 Drop: a capture event while fifo_count == DEPTH and no pop SHALL leave FIFO contents unchanged, set overflow, and increment drop_cnt.
REQ-026 drop_cnt SHALL saturate at all-ones and never wrap.
REQ-027 clear SHALL zero overflow and drop_cnt on the next edge and SHALL NOT affect FIFO contents or pointers.
REQ-028 If clear and a drop occur in the same cycle, clear SHALL win: overflow=0 and drop_cnt=0.
REQ-029 trace_ready asserted while trace_valid=0 SHALL have no effect.
REQ-030 Output data SHALL remain stable while trace_valid=1 and trace_ready=0, regardless of pushes.

Reset
REQ-031 When reset=1 at an edge, pointers, fifo_count, overflow and drop_cnt SHALL become 0 and trace_valid SHALL be 0.
REQ-032 While reset=1, capture events SHALL be ignored.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries. trace_pc, trace_wnum and trace_wdata are don't-care while trace_valid=0.
REQ-034 Storage arrays need not be reset.

Verification
REQ-035 Single event: after reset, one cycle with pc=0xBFC00000, wen=4'hF, wnum=5, wdata=0x12345678 and trace_ready=0 -> next cycle trace_valid=1 with those values and fifo_count=1. One cycle with trace_ready=1 -> trace_valid=0.
REQ-036 Filtering: wen=4'hF with wnum=0, and wen=0 with wnum=7 -> fifo_count stays 0 and trace_valid stays 0.
REQ-037 Overflow: DEPTH=8, trace_ready=0, 10 consecutive events with wdata=1..10 -> fifo_count=8, overflow=1, drop_cnt=2. Draining then yields wdata 1..8 in order.
REQ-038 Full with simultaneous push and pop: FIFO full, trace_ready=1 and an event with wdata=0xAA -> fifo_count stays 8, no drop, and 0xAA appears as the last entry drained.
REQ-039 Clear/saturation: CNT_W=2 with 5 drops -> drop_cnt=3. Then clear together with a further drop -> overflow=0, drop_cnt=0, fifo_count=8.
REQ-040 Reset mid-operation: fifo_count=5, then reset=1 for one cycle -> fifo_count=0, trace_valid=0, overflow=0. The next event is captured normally.

Source files
------------

// File: rtl/wb_trace_buffer_if.sv
// Writeback trace capture bus: CPU debug writeback port in,
// show-ahead trace stream and status out.
interface wb_trace_buffer_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  logic [31:0]              debug_wb_pc;
  logic [3:0]               debug_wb_rf_wen;
  logic [4:0]               debug_wb_rf_wnum;
  logic [31:0]              debug_wb_rf_wdata;
  logic                     clear;
  logic                     trace_valid;
  logic                     trace_ready;
  logic [31:0]              trace_pc;
  logic [4:0]               trace_wnum;
  logic [31:0]              trace_wdata;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;
  logic [CNT_W-1:0]         drop_cnt;

  modport master (
    output debug_wb_pc, debug_wb_rf_wen,
    output debug_wb_rf_wnum, debug_wb_rf_wdata,
    output clear, trace_ready,
    input  trace_valid, trace_pc, trace_wnum,
    input  trace_wdata, fifo_count,
    input  overflow, drop_cnt
  );

  modport slave (
    input  debug_wb_pc, debug_wb_rf_wen,
    input  debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  clear, trace_ready,
    output trace_valid, trace_pc, trace_wnum,
    output trace_wdata, fifo_count,
    output overflow, drop_cnt
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Captures register-file writebacks into a show-ahead FIFO,
// counting events dropped while the FIFO is full.
module wb_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  wb_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]      pc_mem   [DEPTH];
  logic [4:0]       wnum_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW:0]      count;
  logic             ovf;
  logic [CNT_W-1:0] drops;

  logic capture;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    capture = (|bus.debug_wb_rf_wen) &&
              (|bus.debug_wb_rf_wnum);
    full    = count == (AW+1)'(DEPTH);
    pop     = (count != '0) && bus.trace_ready;
    // A pop on a full FIFO frees the slot the push needs.
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count + (AW+1)'(push)
                     - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      ovf   <= 1'b0;
      drops <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drops != '1) drops <= drops + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[tail]   <= bus.debug_wb_pc;
      wnum_mem[tail] <= bus.debug_wb_rf_wnum;
      data_mem[tail] <= bus.debug_wb_rf_wdata;
    end
  end

  assign bus.trace_valid = count != '0;
  assign bus.trace_pc    = pc_mem[head];
  assign bus.trace_wnum  = wnum_mem[head];
  assign bus.trace_wdata = data_mem[head];
  assign bus.fifo_count  = count;
  assign bus.overflow    = ovf;
  assign bus.drop_cnt    = drops;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: directed table, corner sequences
// and random traffic against a queue-based reference model.
module tb_wb_trace_buffer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_trace_buffer_if #(.DEPTH(DEPTH), .CNT_W(16)) b();
  wb_trace_buffer_if #(.DEPTH(DEPTH), .CNT_W(2))  s();

  assign s.debug_wb_pc       = b.debug_wb_pc;
  assign s.debug_wb_rf_wen   = b.debug_wb_rf_wen;
  assign s.debug_wb_rf_wnum  = b.debug_wb_rf_wnum;
  assign s.debug_wb_rf_wdata = b.debug_wb_rf_wdata;
  assign s.clear             = b.clear;
  assign s.trace_ready       = b.trace_ready;

  wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(b)
  );
  wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(s)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } ent_t;

  ent_t q[$];
  int   drops;
  bit   ovf;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(logic [31:0] pc, logic [3:0] wen,
                       logic [4:0] wnum, logic [31:0] wd,
                       logic rdy, logic clr);
    b.debug_wb_pc       = pc;
    b.debug_wb_rf_wen   = wen;
    b.debug_wb_rf_wnum  = wnum;
    b.debug_wb_rf_wdata = wd;
    b.trace_ready       = rdy;
    b.clear             = clr;
  endtask

  task automatic ev(logic [31:0] wd, logic rdy, logic clr);
    drive(32'h1000 + wd * 4, 4'hF, 5'd3, wd, rdy, clr);
  endtask

  task automatic idle(logic rdy);
    drive('0, 4'h0, 5'd0, '0, rdy, 1'b0);
  endtask

  // Model advance from the inputs in force, then clock.
  task automatic tick();
    bit   cap;
    bit   pop;
    ent_t e;
    cap = (b.debug_wb_rf_wen != 0) &&
          (b.debug_wb_rf_wnum != 0);
    pop = (q.size() != 0) && (b.trace_ready == 1'b1);
    if (reset) begin
      q.delete();
      drops = 0;
      ovf   = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) begin
          e.pc    = b.debug_wb_pc;
          e.wnum  = b.debug_wb_rf_wnum;
          e.wdata = b.debug_wb_rf_wdata;
          q.push_back(e);
        end else begin
          drops++;
          ovf = 1;
        end
      end
      if (b.clear) begin
        drops = 0;
        ovf   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    int d16;
    int d2;
    d16 = drops > 65535 ? 65535 : drops;
    d2  = drops > 3 ? 3 : drops;
    chk("m_valid", 64'(b.trace_valid), 64'(q.size() != 0));
    chk("m_count", 64'(b.fifo_count), 64'(q.size()));
    chk("m_ovf", 64'(b.overflow), 64'(ovf));
    chk("m_drop", 64'(b.drop_cnt), 64'(d16));
    chk("m_sat_drop", 64'(s.drop_cnt), 64'(d2));
    chk("m_sat_count", 64'(s.fifo_count), 64'(q.size()));
    if (q.size() != 0) begin
      chk("m_pc", 64'(b.trace_pc), 64'(q[0].pc));
      chk("m_wnum", 64'(b.trace_wnum), 64'(q[0].wnum));
      chk("m_wdata", 64'(b.trace_wdata), 64'(q[0].wdata));
      chk("m_sat_wdata", 64'(s.trace_wdata),
          64'(q[0].wdata));
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        rdy;
    logic        e_valid;
    int          e_count;
    logic [31:0] e_pc;
    logic [4:0]  e_wnum;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vt[7];
  logic [31:0] drain_exp[8];

  initial begin
    vt[0] = '{1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{0, 32'hBFC00000, 4'hF, 5, 32'h12345678, 0,
              1, 1, 32'hBFC00000, 5, 32'h12345678};
    vt[2] = '{0, 0, 4'h0, 0, 0, 0,
              1, 1, 32'hBFC00000, 5, 32'h12345678};
    vt[3] = '{0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0};
    vt[4] = '{0, 32'h40, 4'hF, 0, 32'h55, 0, 0, 0, 0, 0, 0};
    vt[5] = '{0, 32'h44, 4'h0, 7, 32'h66, 0, 0, 0, 0, 0, 0};
    vt[6] = '{0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0};

    reset = 1'b1;
    idle(1'b0);
    drops = 0;
    ovf   = 0;

    for (int i = 0; i < 7; i++) begin
      reset = vt[i].rst;
      drive(vt[i].pc, vt[i].wen, vt[i].wnum, vt[i].wdata,
            vt[i].rdy, 1'b0);
      tick();
      chk("t_valid", 64'(b.trace_valid), 64'(vt[i].e_valid));
      chk("t_count", 64'(b.fifo_count), 64'(vt[i].e_count));
      if (vt[i].e_valid) begin
        chk("t_pc", 64'(b.trace_pc), 64'(vt[i].e_pc));
        chk("t_wnum", 64'(b.trace_wnum), 64'(vt[i].e_wnum));
        chk("t_wdata", 64'(b.trace_wdata), 64'(vt[i].e_wdata));
      end
      check_model();
    end
    reset = 1'b0;

    // Overflow, full push+pop and ordered drain.
    reset = 1'b1; idle(1'b0); tick(); reset = 1'b0;
    chk("rst_count", 64'(b.fifo_count), 64'd0);
    ev(32'd1, 1'b0, 1'b0);
    #1;
    chk("no_bypass", 64'(b.trace_valid), 64'd0);
    tick();
    for (int k = 2; k <= 10; k++) begin
      ev(32'(k), 1'b0, 1'b0);
      tick();
      chk("stable_head", 64'(b.trace_wdata), 64'd1);
    end
    chk("ovf_count", 64'(b.fifo_count), 64'd8);
    chk("ovf_flag", 64'(b.overflow), 64'd1);
    chk("ovf_drops", 64'(b.drop_cnt), 64'd2);
    ev(32'hAA, 1'b1, 1'b0);
    tick();
    chk("fpp_count", 64'(b.fifo_count), 64'd8);
    chk("fpp_drops", 64'(b.drop_cnt), 64'd2);
    for (int k = 0; k < 7; k++) drain_exp[k] = 32'(k + 2);
    drain_exp[7] = 32'hAA;
    idle(1'b1);
    for (int k = 0; k < 8; k++) begin
      chk("drain", 64'(b.trace_wdata), 64'(drain_exp[k]));
      tick();
    end
    chk("drain_empty", 64'(b.trace_valid), 64'd0);
    check_model();

    // Saturation and clear racing a drop.
    reset = 1'b1; idle(1'b0); tick(); reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      ev(32'(k), 1'b0, 1'b0);
      tick();
    end
    chk("sat_drop2", 64'(s.drop_cnt), 64'd3);
    chk("sat_drop16", 64'(b.drop_cnt), 64'd5);
    ev(32'd14, 1'b0, 1'b1);
    tick();
    chk("clr_ovf", 64'(s.overflow), 64'd0);
    chk("clr_drop", 64'(s.drop_cnt), 64'd0);
    chk("clr_drop16", 64'(b.drop_cnt), 64'd0);
    chk("clr_count", 64'(s.fifo_count), 64'd8);
    chk("clr_head", 64'(b.trace_wdata), 64'd1);
    check_model();

    // Reset mid-operation.
    reset = 1'b1; idle(1'b0); tick(); reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      ev(32'(k + 16), 1'b0, 1'b0);
      tick();
    end
    chk("mid_count5", 64'(b.fifo_count), 64'd5);
    reset = 1'b1;
    ev(32'h77, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    chk("mid_count0", 64'(b.fifo_count), 64'd0);
    chk("mid_valid", 64'(b.trace_valid), 64'd0);
    chk("mid_ovf", 64'(b.overflow), 64'd0);
    ev(32'h99, 1'b0, 1'b0);
    tick();
    chk("mid_next_cnt", 64'(b.fifo_count), 64'd1);
    chk("mid_next_dat", 64'(b.trace_wdata), 64'h99);

    // Random traffic with phases that favour filling or draining.
    for (int i = 0; i < 3000; i++) begin
      int rp;
      rp = ((i / 200) % 2 == 1) ? 80 : 20;
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom,
            ($urandom_range(0, 3) == 0) ? 4'h0
                                        : 4'($urandom),
            5'($urandom),
            $urandom,
            ($urandom_range(0, 99) < rp),
            ($urandom_range(0, 59) == 0));
      tick();
      check_model();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
